// File: rtl/add3_sched_pkg.sv
// Shared sizing, pipeline depth and round-robin pointer update for the
// three-operand adder scheduler.
package add3_pkg;
  localparam int NREQ_DEF   = 4;
  localparam int W_DEF      = 10;
  localparam int SUM_W_DEF  = W_DEF + 2;
  localparam int PIPE_DEPTH = 2;

  // Next priority pointer: the requester just after the winner, wrapping.
  function automatic int rr_next(input int cur, input int n);
    return (cur + 1 == n) ? 0 : cur + 1;
  endfunction
endpackage

// File: rtl/add3_sched_if.sv
// Request fan-in and single response channel of the adder scheduler.
interface add3_sched_if #(
  parameter int NREQ = add3_pkg::NREQ_DEF,
  parameter int W    = add3_pkg::W_DEF
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][W-1:0] req_in1;
  logic [NREQ-1:0][W-1:0] req_in2;
  logic [NREQ-1:0][W-1:0] req_in3;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [W+1:0]           rsp_sum;
  logic                   busy;

  modport master (
    output req_valid, req_in1, req_in2, req_in3, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, busy
  );

  modport slave (
    input  req_valid, req_in1, req_in2, req_in3, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, busy
  );
endinterface

// File: rtl/add3_sched_pipe.sv
// Two-stage enabled adder: stage 1 forms in1+in2 and carries in3, stage 2
// adds in3. The requester id travels with the data.
module add3_pipe
  import add3_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           v_in,
  input  logic [IDW-1:0] id_in,
  input  logic [W-1:0]   in1,
  input  logic [W-1:0]   in2,
  input  logic [W-1:0]   in3,
  output logic           v_out,
  output logic [IDW-1:0] id_out,
  output logic [W+1:0]   sum,
  output logic           busy
);
  logic [PIPE_DEPTH:1] r_vld_pipe;
  logic [W:0]          r_s1_sum;
  logic [W-1:0]        r_s1_in3;
  logic [IDW-1:0]      r_s1_id;
  logic [IDW-1:0]      r_id_out;
  logic [W+1:0]        r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_s1_sum   <= '0;
      r_s1_in3   <= '0;
      r_s1_id    <= '0;
      r_id_out   <= '0;
      r_sum      <= '0;
    end else if (en) begin
      r_vld_pipe <= {r_vld_pipe[PIPE_DEPTH-1:1], v_in};
      r_s1_sum   <= {1'b0, in1} + {1'b0, in2};
      r_s1_in3   <= in3;
      r_s1_id    <= id_in;
      r_sum      <= {1'b0, r_s1_sum} + {2'b00, r_s1_in3};
      r_id_out   <= r_s1_id;
    end
  end

  assign v_out  = r_vld_pipe[PIPE_DEPTH];
  assign id_out = r_id_out;
  assign sum    = r_sum;
  assign busy   = |r_vld_pipe;
endmodule

// File: rtl/add3_sched.sv
// Round-robin scheduler sharing one pipelined three-operand adder among
// NREQ requesters; results leave in issue order with backpressure.
module add3_sched
  import add3_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic         clk,
  input logic         rst_n,
  add3_sched_if.slave bus
);
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_gnt;
  logic [IDW-1:0] w_idx;
  logic           w_found;
  logic           w_adv;
  logic           w_accept;
  logic           w_busy;

  // The whole pipeline freezes while a result sits unaccepted at the output.
  assign w_adv    = !(bus.rsp_valid && !bus.rsp_ready);
  assign w_accept = w_adv && w_found;

  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (w_accept) bus.req_ready[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ptr <= '0;
    else if (w_accept) r_ptr <= IDW'(rr_next(int'(w_gnt), NREQ));
  end

  add3_pipe #(.W(W), .IDW(IDW)) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (w_adv),
    .v_in   (w_accept),
    .id_in  (w_gnt),
    .in1    (bus.req_in1[w_gnt]),
    .in2    (bus.req_in2[w_gnt]),
    .in3    (bus.req_in3[w_gnt]),
    .v_out  (bus.rsp_valid),
    .id_out (bus.rsp_id),
    .sum    (bus.rsp_sum),
    .busy   (w_busy)
  );

  assign bus.busy = w_busy;
endmodule

// File: tb/tb_add3_sched.sv
// Randomized and directed bench for add3_sched against a transaction-level
// model of arbitration and in-flight results.
module tb_add3_sched;
  import add3_pkg::*;
  localparam int NREQ = NREQ_DEF;
  localparam int W    = W_DEF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  add3_sched_if #(.NREQ(NREQ), .W(W)) bus ();
  add3_sched #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  // stimulus
  logic [NREQ-1:0] vld;
  int a1[NREQ], a2[NREQ], a3[NREQ];
  bit rr;

  // model: priority pointer plus the two in-flight results as whole sums
  int m_ptr;
  bit m1_v, mo_v;
  int m1_id, mo_id, m1_sum, mo_sum;
  logic [31:0] obs_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus.req_valid = vld;
    bus.rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_in1[i] = W'(a1[i]);
      bus.req_in2[i] = W'(a2[i]);
      bus.req_in3[i] = W'(a3[i]);
    end
  endtask

  function automatic int exp_gnt();
    for (int k = 0; k < NREQ; k++)
      if (vld[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_clear();
    m_ptr = 0; m1_v = 0; mo_v = 0;
    m1_id = 0; mo_id = 0; m1_sum = 0; mo_sum = 0;
  endtask

  // One clock: drive at negedge, check handshake, advance model, check outputs.
  task automatic step();
    int g;
    bit adv;
    drive();
    #1;
    adv = !(mo_v && !rr);
    g = exp_gnt();
    obs_rdy = 32'(bus.req_ready);
    chk("req_ready", obs_rdy, (adv && g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    if (adv) begin
      mo_v = m1_v; mo_id = m1_id; mo_sum = m1_sum;
      m1_v = (g >= 0);
      if (g >= 0) begin
        m1_id  = g;
        m1_sum = a1[g] + a2[g] + a3[g];
        m_ptr  = (g + 1) % NREQ;
      end
    end
    @(negedge clk);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(mo_v));
    chk("busy", 32'(bus.busy), 32'(m1_v || mo_v));
    if (mo_v) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(mo_id));
      chk("rsp_sum", 32'(bus.rsp_sum), 32'(mo_sum));
    end
  endtask

  task automatic set_ops(input int v);
    for (int i = 0; i < NREQ; i++) begin a1[i] = v; a2[i] = v; a3[i] = v; end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      a1[i] = int'($urandom_range(0, (1 << W) - 1));
      a2[i] = int'($urandom_range(0, (1 << W) - 1));
      a3[i] = int'($urandom_range(0, (1 << W) - 1));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vld = '0; rr = 1'b1; set_ops(0);
    drive();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_rsp_sum", 32'(bus.rsp_sum), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // single request from requester 2 with all-ones operands
    vld = 4'b0100; set_ops(1023); rr = 1'b1;
    step();
    chk("single_grant", obs_rdy, 32'b0100);
    vld = '0;
    step();
    chk("single_valid", 32'(bus.rsp_valid), 1);
    chk("single_sum", 32'(bus.rsp_sum), 3069);
    chk("single_id", 32'(bus.rsp_id), 2);
    step();
    chk("single_busy_low", 32'(bus.busy), 0);

    // full contention from a fresh pointer
    do_reset();
    vld = '1; rr = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rand_ops();
      step();
      chk("contend_grant", obs_rdy, 32'd1 << (c % NREQ));
    end
    vld = '0;
    step(); step();

    // backpressure on a stream from requester 1
    vld = 4'b0010; rr = 1'b1;
    rand_ops(); step();
    rand_ops(); step();
    rr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_ops();
      step();
      chk("stall_ready", obs_rdy, 0);
    end
    rr = 1'b1;
    rand_ops(); step();
    vld = '0;
    step(); step();

    // wrap-around: move pointer to 3, then only 0 and 3 request
    vld = 4'b0100; rand_ops(); step();
    vld = 4'b1001;
    step();
    chk("wrap_first", obs_rdy, 32'b1000);
    step();
    chk("wrap_second", obs_rdy, 32'b0001);
    vld = '0;
    step(); step();

    // zero operands still produce a valid result
    vld = 4'b0001; set_ops(0); step();
    vld = '0; step();
    chk("zero_valid", 32'(bus.rsp_valid), 1);
    chk("zero_sum", 32'(bus.rsp_sum), 0);
    step();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      vld = NREQ'($urandom);
      rr  = ($urandom_range(0, 3) != 0);
      rand_ops();
      step();
    end

    // asynchronous reset with two ops in flight
    rr = 1'b1; vld = '1;
    rand_ops(); step();
    rand_ops(); step();
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    vld = '1; rand_ops();
    step();
    chk("arst_ptr0", obs_rdy, 32'b0001);
    vld = '0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
